// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync polarity levels and lock FSM states
// for the VGA sync-to-count receiver.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Load positions are one column past the sync start: the syncs arrive one clock late.
    localparam int VS_PX_LOAD_DEF  = 1;
    localparam int VS_PY_LOAD_DEF  = V_ACTIVE_DEF + V_FRONT_DEF;
    localparam int HS_PX_LOAD_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + 1;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        COUNTING = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Sync history register plus assertion-edge pulse. History resets to the
// deasserted level and the detector stays disarmed for the first clock after reset.
module sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sync,
    output logic o_sync_d,
    output logic o_edge
);

    logic r_armed;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_sync_d <= ~SYNC_POL;
            r_armed  <= 1'b0;
        end else begin
            o_sync_d <= i_sync;
            r_armed  <= 1'b1;
        end
    end

    // Disarmed on the first clock so a sync held asserted through reset exit is not an edge.
    assign o_edge = r_armed && (i_sync == SYNC_POL) && (o_sync_d != SYNC_POL);

endmodule

// File: rtl/vga_sync_to_count.sv
// Recovers pixel coordinates from same-domain HSync/VSync and reports cadence lock.
// Define VGA_SYNC_HS_CHECK_EN to also realign and check the column on HSync edges.
//
// state    | meaning
// UNLOCKED | last edge mismatched, sync lost, or fresh out of reset
// COUNTING | good edges seen, fewer than LOCK_FRAMES in a row
// LOCKED   | LOCK_FRAMES consecutive good edges, cadence matches geometry
module vga_sync_to_count
    import vga_timing_pkg::*;
#(
    parameter int   H_TOTAL     = H_TOTAL_DEF,
    parameter int   V_TOTAL     = V_TOTAL_DEF,
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter logic SYNC_POL    = SYNC_ACTIVE_LOW,
    parameter int   VS_PX_LOAD  = VS_PX_LOAD_DEF,
    parameter int   VS_PY_LOAD  = VS_PY_LOAD_DEF,
`ifdef VGA_SYNC_HS_CHECK_EN
    parameter int   HS_PX_LOAD  = HS_PX_LOAD_DEF,
`endif
    parameter int   LOCK_FRAMES = LOCK_FRAMES_DEF,
    localparam int  PX_W        = $clog2(H_TOTAL),
    localparam int  PY_W        = $clog2(V_TOTAL)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_hs,
    input  logic            i_vs,
    output logic            o_hs,
    output logic            o_vs,
    output logic [PX_W-1:0] o_px,
    output logic [PY_W-1:0] o_py,
    output logic            o_activeArea,
    output logic            o_frameStrobe,
    output logic            o_locked
);

    localparam int              CNT_W        = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] LOCK_CNT_MAX = CNT_W'(LOCK_FRAMES);

    logic            vs_edge;
    logic            vs_match;
    logic [PX_W-1:0] px_free, px_nx;
    logic [PY_W-1:0] py_free, py_nx;
    logic            ev_good, ev_bad;
    lock_state_e     r_state, state_nx;
    logic [CNT_W-1:0] r_goodCnt, cnt_nx;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_sync   (i_vs),
        .o_sync_d (o_vs),
        .o_edge   (vs_edge)
    );

`ifdef VGA_SYNC_HS_CHECK_EN
    logic hs_edge;
    logic hs_match;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_sync   (i_hs),
        .o_sync_d (o_hs),
        .o_edge   (hs_edge)
    );

    assign hs_match = (px_free == PX_W'(HS_PX_LOAD));
`else
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) o_hs <= ~SYNC_POL;
        else          o_hs <= i_hs;
    end
`endif

    always_comb begin
        px_free = (o_px == PX_W'(H_TOTAL - 1)) ? '0 : o_px + 1'b1;
        py_free = o_py;
        if (o_px == PX_W'(H_TOTAL - 1))
            py_free = (o_py == PY_W'(V_TOTAL - 1)) ? '0 : o_py + 1'b1;
    end

    assign vs_match = (px_free == PX_W'(VS_PX_LOAD)) && (py_free == PY_W'(VS_PY_LOAD));

    // VSync outranks HSync; reaching a load position without its edge counts as lost sync.
    always_comb begin
        px_nx   = px_free;
        py_nx   = py_free;
        ev_good = 1'b0;
        ev_bad  = 1'b0;
        if (vs_edge) begin
            px_nx   = PX_W'(VS_PX_LOAD);
            py_nx   = PY_W'(VS_PY_LOAD);
            ev_good = vs_match;
            ev_bad  = !vs_match;
        end else if (vs_match) begin
            ev_bad = 1'b1;
        end
`ifdef VGA_SYNC_HS_CHECK_EN
        else if (hs_edge) begin
            px_nx  = PX_W'(HS_PX_LOAD);
            py_nx  = o_py;
            ev_bad = !hs_match;
        end else if (hs_match) begin
            ev_bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_px          <= '0;
            o_py          <= '0;
            o_activeArea  <= 1'b0;
            o_frameStrobe <= 1'b0;
        end else begin
            o_px          <= px_nx;
            o_py          <= py_nx;
            o_activeArea  <= (px_nx < PX_W'(H_ACTIVE)) && (py_nx < PY_W'(V_ACTIVE));
            o_frameStrobe <= (px_nx == '0) && (py_nx == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= UNLOCKED;
            r_goodCnt <= '0;
        end else begin
            r_state   <= state_nx;
            r_goodCnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = r_state;
        cnt_nx   = r_goodCnt;
        if (ev_bad) begin
            state_nx = UNLOCKED;
            cnt_nx   = '0;
        end else if (ev_good) begin
            cnt_nx   = (r_goodCnt == LOCK_CNT_MAX) ? r_goodCnt : r_goodCnt + 1'b1;
            state_nx = (cnt_nx == LOCK_CNT_MAX) ? LOCKED : COUNTING;
        end
    end

    assign o_locked = (r_state == LOCKED);

endmodule

// File: doc/vga_sync_to_count.md
# vga_sync_to_count

Recovers pixel coordinates from a VGA HSync/VSync pair generated in the same clock domain: the receive end of the sync interface driven by the VGA sync generator. It re-aligns free-running column/row counters on each VSync assertion edge, checks that the sync cadence matches the configured frame geometry, and reports lock. The block sits between the sync generator (or an upstream pattern/video stage) and pixel consumers that need `o_px`/`o_py` aligned with the delayed syncs.

## Interface
- `H_TOTAL`, 800: clocks per line.
- `V_TOTAL`, 525: lines per frame.
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `SYNC_POL`, 0: asserted sync level; 0 = active-low.
- `VS_PX_LOAD`, 1: column loaded on VSync edge.
- `VS_PY_LOAD`, 490: row loaded on VSync edge.
- `HS_PX_LOAD`, 657: column loaded on HSync edge (macro-gated).
- `LOCK_FRAMES`, 2: consecutive good frames to lock.
- `i_clk` in 1: system clock.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_hs` in 1: HSync, same clock domain.
- `i_vs` in 1: VSync, same clock domain.
- `o_hs` out 1: `i_hs` delayed 1 clock.
- `o_vs` out 1: `i_vs` delayed 1 clock.
- `o_px` out clog2(H_TOTAL): column of current `o_hs`/`o_vs` cycle.
- `o_py` out clog2(V_TOTAL): row of current cycle.
- `o_activeArea` out 1: `o_px < H_ACTIVE && o_py < V_ACTIVE`, registered with counters.
- `o_frameStrobe` out 1: 1-clock pulse when (`o_px`,`o_py`) = (0,0).
- `o_locked` out 1: sync cadence matches geometry.

## Operation
- Reset: `o_px`=0, `o_py`=0, `o_activeArea`=0, `o_frameStrobe`=0, `o_locked`=0; `o_hs`/`o_vs` and internal sync history = deasserted level (`~SYNC_POL`), so a sync held asserted through reset exit yields no edge.
- Free-run: next column = `o_px`+1; at `H_TOTAL`-1 wraps to 0 and row increments; row wraps at `V_TOTAL`-1 to 0.
- VSync edge: `i_vs` asserted while previous-cycle `i_vs` deasserted. On edge, next `o_px`=`VS_PX_LOAD`, `o_py`=`VS_PY_LOAD`, overriding free-run.
- Lock FSM (UNLOCKED, COUNTING, LOCKED), `r_goodCnt` saturating at `LOCK_FRAMES`:
  - Edge where free-run next position already equals load position: good frame, `r_goodCnt`++; reaching `LOCK_FRAMES` enters LOCKED.
  - Edge at any other position: mismatch; `r_goodCnt`=0, UNLOCKED.
  - Free-run next position equals load position with no edge: lost sync; `r_goodCnt`=0, UNLOCKED.
  - First edge after reset counts as mismatch (counters unaligned) unless position coincidentally matches.
- Outputs continue to count while unlocked; consumers gate on `o_locked`.

## Timing
- All outputs registered; `o_px`/`o_py`/`o_activeArea`/`o_frameStrobe` valid on the same cycle as `o_hs`/`o_vs` (1-clock latency from `i_hs`/`i_vs`).
- Edge on input at cycle N: load values visible on outputs at N+1; `o_vs` asserted at N+1 as well.
- `o_locked` rises on cycle after the `LOCK_FRAMES`-th good edge; falls on cycle after mismatch/loss.
- Asynchronous reset mid-frame: all state cleared immediately; relock requires fresh edges.

## Configuration
- `VGA_SYNC_HS_CHECK_EN` defined: HSync edges also detected; on edge, next `o_px`=`HS_PX_LOAD` (row unchanged); edge at any other free-run position is a mismatch and clears lock; HSync edge absent where expected clears lock. VSync edge takes priority when both edges occur on the same cycle.
- Undefined: `i_hs` only delayed to `o_hs`; no HSync edge logic synthesised.

## Structure
- `vga_timing_pkg`: 640x480@60 constants (H/V totals, active sizes, porch and sync widths), default load positions, sync polarity constants, lock FSM state typedef.
- One sub-module: `sync_edge_detect` (history register with polarity-aware reset, assertion-edge pulse); instantiated for VSync and, with the macro, HSync.

## Test plan
- Reset with `i_vs` held asserted, release -> no load, `o_px` counts 0,1,2...; `o_locked`=0.
- Drive VGA sync generator at defaults for 3 frames -> `o_locked`=1 after second matching edge; `o_frameStrobe` once per 420000 clocks; `o_activeArea` high 640 clocks per line for rows 0-479.
- Locked, delay one VSync edge by 5 clocks -> `o_locked` falls on cycle after expected position; edge loads (1,490); relocks after 2 further good frames.
- Locked, suppress VSync one frame -> `o_locked`=0; counters keep wrapping at 800/525.
- Macro defined, shift one HSync edge by 3 clocks -> `o_px`=657 on following cycle, `o_locked`=0; coincident VSync+HSync edge -> (1,490) loaded.
- Assert `i_reset` mid-line at `o_px`=300 -> all outputs at reset values same cycle, `o_hs`/`o_vs`=1.
